elapsed_timer: RTL and testbench

Count-up counterpart to the countdown timer. Measures elapsed run time in 100 ms units and shows it as four BCD digits (000.0–999.9 s) for the score/HUD display. Provides start/stop/clear control, a lap capture register and saturation detection. The game FSM drives it; the display path and score logic read it.

---
 rtl/elapsed_timer.sv | 127 ++++++++++++
 tb/tb_elapsed_timer.sv | 310 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/elapsed_timer.sv
// Count-up run timer: 100 ms prescaler feeding a four-digit BCD counter (000.0-999.9 s)
// with start/stop/clear control, lap capture and saturation at 999.9.
module elapsed_timer #(
  parameter logic [24:0] ONEHUNDRED_MS_PERIOD = 25'd6_500_000
) (
  input  logic        clk_in,
  input  logic        rst_in,
  input  logic        start_in,
  input  logic        stop_in,
  input  logic        clear_in,
  input  logic        capture_in,
  output logic [15:0] digits_out,
  output logic        running_out,
  output logic        saturated_out,
  output logic        tick_out,
  output logic [15:0] capture_out,
  output logic        capture_valid_out
);

  // Control handshake: every control input is a one-cycle pulse sampled on the
  // rising edge; there is no ready path, so pulses are never stalled or queued.

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    RUN    = 2'd1,
    PAUSED = 2'd2,
    SAT    = 2'd3
  } state_t;

  localparam logic [24:0] TERMINAL = ONEHUNDRED_MS_PERIOD - 25'd1;
  localparam logic [15:0] FULL     = 16'h9999;

  state_t      state, state_next;
  logic [24:0] presc, presc_next;
  logic [15:0] digits, digits_next;
  logic        tick_next;
  logic [15:0] digits_inc;

  // Ripple-carry BCD increment; each nibble wraps 9 -> 0 and carries upward.
  function automatic logic [15:0] bcd_inc(input logic [15:0] v);
    logic [15:0] r;
    logic        carry;
    r     = v;
    carry = 1'b1;
    for (int i = 0; i < 4; i++) begin
      if (carry) begin
        if (v[i*4 +: 4] >= 4'd9) begin
          r[i*4 +: 4] = 4'd0;
        end else begin
          r[i*4 +: 4] = v[i*4 +: 4] + 4'd1;
          carry       = 1'b0;
        end
      end
    end
    return r;
  endfunction

  assign digits_inc = bcd_inc(digits);

  always_comb begin
    state_next  = state;
    presc_next  = presc;
    digits_next = digits;
    tick_next   = 1'b0;
    if (clear_in) begin
      state_next  = IDLE;
      presc_next  = '0;
      digits_next = '0;
    end else begin
      case (state)
        IDLE: begin
          digits_next = '0;
          if (!stop_in && start_in) begin
            state_next = RUN;
            presc_next = '0;
          end
        end
        RUN: begin
          // A stop on the terminal-count cycle suppresses that increment.
          if (stop_in) begin
            state_next = PAUSED;
          end else if (presc == TERMINAL) begin
            presc_next  = '0;
            digits_next = digits_inc;
            tick_next   = 1'b1;
            if (digits_inc == FULL) state_next = SAT;
          end else begin
            presc_next = presc + 25'd1;
          end
        end
        PAUSED: begin
          // Resume keeps the partial prescaler period.
          if (!stop_in && start_in) state_next = RUN;
        end
        SAT: begin
          digits_next = FULL;
        end
        default: state_next = IDLE;
      endcase
    end
  end

  always_ff @(posedge clk_in or negedge rst_in) begin
    if (!rst_in) begin
      state             <= IDLE;
      presc             <= '0;
      digits            <= '0;
      tick_out          <= 1'b0;
      running_out       <= 1'b0;
      saturated_out     <= 1'b0;
      capture_out       <= '0;
      capture_valid_out <= 1'b0;
    end else begin
      state             <= state_next;
      presc             <= presc_next;
      digits            <= digits_next;
      tick_out          <= tick_next;
      running_out       <= (state_next == RUN);
      saturated_out     <= (state_next == SAT);
      capture_valid_out <= capture_in;
      if (capture_in) capture_out <= digits;
    end
  end

  assign digits_out = digits;

endmodule

// File: tb/tb_elapsed_timer.sv
// Bench for elapsed_timer: two instances (period 4 and period 2) share stimulus and are
// compared every cycle against an integer-count reference model, plus directed sequences.
module tb_elapsed_timer;

  logic clk;
  logic rst_n;
  logic start, stop, clear, capture;

  logic [15:0] digits_o   [2];
  logic        running_o  [2];
  logic        sat_o      [2];
  logic        tick_o     [2];
  logic [15:0] cap_o      [2];
  logic        cv_o       [2];

  int checks = 0;
  int errors = 0;

  elapsed_timer #(.ONEHUNDRED_MS_PERIOD(25'd4)) dut4 (
    .clk_in(clk), .rst_in(rst_n), .start_in(start), .stop_in(stop),
    .clear_in(clear), .capture_in(capture), .digits_out(digits_o[0]),
    .running_out(running_o[0]), .saturated_out(sat_o[0]), .tick_out(tick_o[0]),
    .capture_out(cap_o[0]), .capture_valid_out(cv_o[0])
  );

  elapsed_timer #(.ONEHUNDRED_MS_PERIOD(25'd2)) dut2 (
    .clk_in(clk), .rst_in(rst_n), .start_in(start), .stop_in(stop),
    .clear_in(clear), .capture_in(capture), .digits_out(digits_o[1]),
    .running_out(running_o[1]), .saturated_out(sat_o[1]), .tick_out(tick_o[1]),
    .capture_out(cap_o[1]), .capture_valid_out(cv_o[1])
  );

  // clock / reset
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // reference model: elapsed time as an integer number of tenths
  localparam int M_IDLE = 0, M_RUN = 1, M_PAUSE = 2, M_SAT = 3;
  int per     [2] = '{4, 2};
  int m_count [2];
  int m_presc [2];
  int m_mode  [2];
  int m_tick  [2];
  int m_cap   [2];
  int m_cv    [2];

  function automatic logic [15:0] to_bcd(input int n);
    logic [15:0] r;
    r[15:12] = 4'((n / 1000) % 10);
    r[11:8]  = 4'((n / 100) % 10);
    r[7:4]   = 4'((n / 10) % 10);
    r[3:0]   = 4'(n % 10);
    return r;
  endfunction

  function automatic void model_reset();
    for (int i = 0; i < 2; i++) begin
      m_count[i] = 0; m_presc[i] = 0; m_mode[i] = M_IDLE;
      m_tick[i] = 0; m_cap[i] = 0; m_cv[i] = 0;
    end
  endfunction

  function automatic void model_step(input logic st, input logic sp, input logic cl, input logic cp);
    for (int i = 0; i < 2; i++) begin
      m_cv[i] = cp ? 1 : 0;
      if (cp) m_cap[i] = m_count[i];
      m_tick[i] = 0;
      if (cl) begin
        m_mode[i] = M_IDLE; m_count[i] = 0; m_presc[i] = 0;
      end else if (m_mode[i] == M_RUN) begin
        if (sp) m_mode[i] = M_PAUSE;
        else if (m_presc[i] + 1 == per[i]) begin
          m_presc[i] = 0;
          m_count[i] = m_count[i] + 1;
          m_tick[i] = 1;
          if (m_count[i] == 9999) m_mode[i] = M_SAT;
        end else m_presc[i] = m_presc[i] + 1;
      end else if (m_mode[i] == M_IDLE) begin
        if (st && !sp) begin m_mode[i] = M_RUN; m_presc[i] = 0; end
      end else if (m_mode[i] == M_PAUSE) begin
        if (st && !sp) m_mode[i] = M_RUN;
      end
    end
  endfunction

  // scoreboard
  task automatic check(input string name, input logic [15:0] act, input logic [15:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic logic digits_legal(input logic [15:0] d);
    return (d[3:0] <= 9) && (d[7:4] <= 9) && (d[11:8] <= 9) && (d[15:12] <= 9);
  endfunction

  task automatic compare_all();
    for (int i = 0; i < 2; i++) begin
      check($sformatf("digits[%0d]", i), digits_o[i], to_bcd(m_count[i]));
      check($sformatf("running[%0d]", i), 16'(running_o[i]), 16'(m_mode[i] == M_RUN));
      check($sformatf("saturated[%0d]", i), 16'(sat_o[i]), 16'(m_mode[i] == M_SAT));
      check($sformatf("tick[%0d]", i), 16'(tick_o[i]), 16'(m_tick[i]));
      check($sformatf("capture[%0d]", i), cap_o[i], to_bcd(m_cap[i]));
      check($sformatf("capture_valid[%0d]", i), 16'(cv_o[i]), 16'(m_cv[i]));
      check($sformatf("digit_range[%0d]", i), 16'(digits_legal(digits_o[i])), 16'd1);
    end
  endtask

  task automatic check_all_zero(input string tag);
    for (int i = 0; i < 2; i++) begin
      check($sformatf("%s_digits[%0d]", tag, i), digits_o[i], 16'h0000);
      check($sformatf("%s_flags[%0d]", tag, i),
            {12'd0, running_o[i], sat_o[i], tick_o[i], cv_o[i]}, 16'h0000);
      check($sformatf("%s_capture[%0d]", tag, i), cap_o[i], 16'h0000);
    end
  endtask

  // driver
  task automatic step(input logic st, input logic sp, input logic cl, input logic cp);
    start = st; stop = sp; clear = cl; capture = cp;
    @(posedge clk);
    model_step(st, sp, cl, cp);
    #1;
    compare_all();
  endtask

  task automatic idle(input int n);
    for (int k = 0; k < n; k++) step(1'b0, 1'b0, 1'b0, 1'b0);
  endtask

  task automatic wait_digits(input int inst, input logic [15:0] val, input int budget, input string name);
    int n = 0;
    while (digits_o[inst] !== val && n < budget) begin
      step(1'b0, 1'b0, 1'b0, 1'b0);
      n++;
    end
    check(name, digits_o[inst], val);
  endtask

  task automatic wait_tick(input int inst, input int budget, input string name);
    int n = 0;
    do begin
      step(1'b0, 1'b0, 1'b0, 1'b0);
      n++;
    end while (tick_o[inst] !== 1'b1 && n < budget);
    check(name, 16'(tick_o[inst]), 16'd1);
  endtask

  // table for the period-4 instance, starting from reset
  typedef struct {
    logic        st, sp, cl, cp;
    logic [15:0] exp_digits;
    logic        exp_tick, exp_running, exp_cv;
    logic [15:0] exp_cap;
  } vec_t;

  vec_t vecs [13];

  initial begin
    vecs[0]  = '{1'b1, 1'b0, 1'b0, 1'b0, 16'h0000, 1'b0, 1'b1, 1'b0, 16'h0000};
    vecs[1]  = '{1'b0, 1'b0, 1'b0, 1'b0, 16'h0000, 1'b0, 1'b1, 1'b0, 16'h0000};
    vecs[2]  = '{1'b0, 1'b0, 1'b0, 1'b0, 16'h0000, 1'b0, 1'b1, 1'b0, 16'h0000};
    vecs[3]  = '{1'b0, 1'b0, 1'b0, 1'b0, 16'h0000, 1'b0, 1'b1, 1'b0, 16'h0000};
    vecs[4]  = '{1'b0, 1'b0, 1'b0, 1'b0, 16'h0001, 1'b1, 1'b1, 1'b0, 16'h0000};
    vecs[5]  = '{1'b0, 1'b0, 1'b0, 1'b1, 16'h0001, 1'b0, 1'b1, 1'b1, 16'h0001};
    vecs[6]  = '{1'b0, 1'b1, 1'b0, 1'b0, 16'h0001, 1'b0, 1'b0, 1'b0, 16'h0001};
    vecs[7]  = '{1'b0, 1'b0, 1'b0, 1'b0, 16'h0001, 1'b0, 1'b0, 1'b0, 16'h0001};
    vecs[8]  = '{1'b1, 1'b0, 1'b0, 1'b0, 16'h0001, 1'b0, 1'b1, 1'b0, 16'h0001};
    vecs[9]  = '{1'b0, 1'b0, 1'b0, 1'b0, 16'h0001, 1'b0, 1'b1, 1'b0, 16'h0001};
    vecs[10] = '{1'b0, 1'b0, 1'b0, 1'b0, 16'h0001, 1'b0, 1'b1, 1'b0, 16'h0001};
    vecs[11] = '{1'b0, 1'b0, 1'b0, 1'b0, 16'h0002, 1'b1, 1'b1, 1'b0, 16'h0001};
    vecs[12] = '{1'b1, 1'b0, 1'b1, 1'b0, 16'h0000, 1'b0, 1'b0, 1'b0, 16'h0001};

    start = 1'b0; stop = 1'b0; clear = 1'b0; capture = 1'b0;
    rst_n = 1'b0;
    model_reset();
    repeat (3) @(posedge clk);
    #1;
    check_all_zero("reset");
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    #1;

    // table-driven vectors
    for (int v = 0; v < 13; v++) begin
      step(vecs[v].st, vecs[v].sp, vecs[v].cl, vecs[v].cp);
      check($sformatf("vec%0d_digits", v), digits_o[0], vecs[v].exp_digits);
      check($sformatf("vec%0d_tick", v), 16'(tick_o[0]), 16'(vecs[v].exp_tick));
      check($sformatf("vec%0d_running", v), 16'(running_o[0]), 16'(vecs[v].exp_running));
      check($sformatf("vec%0d_cv", v), 16'(cv_o[0]), 16'(vecs[v].exp_cv));
      check($sformatf("vec%0d_cap", v), cap_o[0], vecs[v].exp_cap);
    end

    // ten ticks at period 4
    step(1'b0, 1'b0, 1'b1, 1'b0);
    step(1'b1, 1'b0, 1'b0, 1'b0);
    idle(40);
    check("ten_ticks_digits", digits_o[0], 16'h0010);
    check("ten_ticks_running", 16'(running_o[0]), 16'd1);

    // BCD carries at period 2
    step(1'b0, 1'b0, 1'b1, 1'b0);
    step(1'b1, 1'b0, 1'b0, 1'b0);
    wait_digits(1, 16'h0099, 400, "reach_0099");
    wait_digits(1, 16'h0100, 4, "carry_0100");
    wait_digits(1, 16'h0999, 2000, "reach_0999");
    wait_digits(1, 16'h1000, 4, "carry_1000");

    // pause/resume at period 4
    step(1'b0, 1'b0, 1'b1, 1'b0);
    step(1'b1, 1'b0, 1'b0, 1'b0);
    wait_tick(0, 8, "pause_first_tick");
    idle(2);
    step(1'b0, 1'b1, 1'b0, 1'b0);
    for (int k = 0; k < 20; k++) begin
      step(1'b0, 1'b0, 1'b0, 1'b0);
      check("paused_digits", digits_o[0], 16'h0001);
      check("paused_running", 16'(running_o[0]), 16'd0);
    end
    step(1'b1, 1'b0, 1'b0, 1'b0);
    check("resume_running", 16'(running_o[0]), 16'd1);
    step(1'b0, 1'b0, 1'b0, 1'b0);
    check("resume_no_tick", 16'(tick_o[0]), 16'd0);
    step(1'b0, 1'b0, 1'b0, 1'b0);
    check("resume_tick", 16'(tick_o[0]), 16'd1);
    check("resume_digits", digits_o[0], 16'h0002);
    idle(3);
    step(1'b0, 1'b1, 1'b0, 1'b0);
    check("stop_at_terminal_digits", digits_o[0], 16'h0002);
    check("stop_at_terminal_tick", 16'(tick_o[0]), 16'd0);
    step(1'b1, 1'b0, 1'b0, 1'b0);
    step(1'b0, 1'b0, 1'b0, 1'b0);
    check("after_terminal_resume", digits_o[0], 16'h0003);

    // capture together with clear
    step(1'b0, 1'b0, 1'b1, 1'b0);
    step(1'b1, 1'b0, 1'b0, 1'b0);
    wait_digits(0, 16'h0123, 600, "reach_0123");
    step(1'b0, 1'b0, 1'b1, 1'b1);
    check("capclr_capture", cap_o[0], 16'h0123);
    check("capclr_valid", 16'(cv_o[0]), 16'd1);
    check("capclr_digits", digits_o[0], 16'h0000);
    step(1'b0, 1'b0, 1'b0, 1'b0);
    check("capclr_valid_drop", 16'(cv_o[0]), 16'd0);
    check("capclr_hold", cap_o[0], 16'h0123);
    step(1'b1, 1'b0, 1'b0, 1'b0);
    step(1'b1, 1'b0, 1'b1, 1'b0);
    check("clear_start_running", 16'(running_o[0]), 16'd0);
    check("clear_start_digits", digits_o[0], 16'h0000);

    // asynchronous reset mid-run
    step(1'b1, 1'b0, 1'b0, 1'b0);
    idle(9);
    #2;
    rst_n = 1'b0;
    #1;
    model_reset();
    check_all_zero("async_reset");
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    idle(6);
    check("post_reset_digits", digits_o[0], 16'h0000);
    check("post_reset_running", 16'(running_o[0]), 16'd0);
    step(1'b1, 1'b0, 1'b0, 1'b0);
    check("post_reset_start", 16'(running_o[0]), 16'd1);

    // randomized control pulses against the model
    for (int k = 0; k < 3000; k++) begin
      step(1'($urandom_range(0, 15) == 0), 1'($urandom_range(0, 19) == 0),
           1'($urandom_range(0, 199) == 0), 1'($urandom_range(0, 7) == 0));
    end

    // saturation at period 2
    step(1'b0, 1'b0, 1'b1, 1'b0);
    step(1'b1, 1'b0, 1'b0, 1'b0);
    begin
      int n = 0;
      while (sat_o[1] !== 1'b1 && n < 20010) begin
        step(1'b0, 1'b0, 1'b0, 1'b0);
        n++;
      end
    end
    check("sat_flag", 16'(sat_o[1]), 16'd1);
    check("sat_digits", digits_o[1], 16'h9999);
    check("sat_running", 16'(running_o[1]), 16'd0);
    for (int k = 0; k < 6; k++) begin
      step(1'(k % 2), 1'b0, 1'b0, 1'b0);
      check("sat_hold_digits", digits_o[1], 16'h9999);
      check("sat_hold_tick", 16'(tick_o[1]), 16'd0);
    end
    step(1'b0, 1'b0, 1'b1, 1'b0);
    check("sat_clear_digits", digits_o[1], 16'h0000);
    check("sat_clear_flag", 16'(sat_o[1]), 16'd0);
    check("sat_clear_running", 16'(running_o[1]), 16'd0);
    idle(3);

    // report
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
